// File: rtl/gfx_pixel_writer.sv
// rtl/gfx_pixel_writer.sv - 8-pixel group writer with depth-tested line-buffer writes
module gfx_pixel_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  render_idx,
    input  logic [31:0] render_data,
    input  logic        render_start,
    input  logic        hflip,
    input  logic [2:0]  palette,
    input  logic [2:0]  zdepth,
    input  logic        zdepth_init,
    output logic        last_pixel,
    output logic        busy,
    output logic [8:0]  wridx,
    output logic [6:0]  wrdata,
    output logic        wren
);

    localparam int unsigned LINE_W = 320;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [8:0]  idx_q;
    logic [31:0] data_q;
    logic        hflip_q;
    logic [2:0]  pal_q;
    logic [2:0]  z_q;
    logic        init_q;
    logic        wren_q;
    logic [8:0]  wridx_q;
    logic [6:0]  wrdata_q;
    logic [2:0]  depth_q [LINE_W];

    logic        accept;
    logic [8:0]  addr;
    logic [3:0]  colour;
    logic        on_screen;
    logic [2:0]  stored;
    logic        wren_d;
    logic [2:0]  depth_d;

    assign busy       = (state_q == ISSUE);
    assign last_pixel = busy && (cnt_q == 3'd7);
    assign accept     = render_start && (!busy || last_pixel);

    // Unflipped pixel i sits at bit 4*(7-i), which is {~i, 2'b00}.
    assign addr      = idx_q + {6'd0, cnt_q};
    assign colour    = hflip_q ? data_q[{cnt_q, 2'b00} +: 4] : data_q[{~cnt_q, 2'b00} +: 4];
    assign on_screen = (addr < 9'(LINE_W));
    assign stored    = on_screen ? depth_q[addr] : 3'd0;
    assign wren_d    = busy && on_screen && (init_q || ((colour != 4'd0) && (z_q > stored)));
    assign depth_d   = (init_q && (colour == 4'd0)) ? 3'd0 : z_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            wren_q   <= 1'b0;
            wridx_q  <= 9'd0;
            wrdata_q <= 7'd0;
        end else begin
            wren_q   <= wren_d;
            wridx_q  <= addr;
            wrdata_q <= {pal_q, colour};
            if (accept) begin
                state_q <= ISSUE;
                cnt_q   <= 3'd0;
                idx_q   <= render_idx;
                data_q  <= render_data;
                hflip_q <= hflip;
                pal_q   <= palette;
                z_q     <= zdepth;
                init_q  <= zdepth_init;
            end else if (busy) begin
                if (last_pixel) begin
                    state_q <= IDLE;
                    cnt_q   <= 3'd0;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
            end
        end
    end

    // Depth is committed together with the registered write decision, so the
    // next issued pixel already reads the updated entry.
    always_ff @(posedge clk) begin
        if (!reset && wren_d) begin
            depth_q[addr] <= depth_d;
        end
    end

    assign wren   = wren_q;
    assign wridx  = wridx_q;
    assign wrdata = wrdata_q;

endmodule

// File: tb/tb_gfx_pixel_writer.sv
// tb/tb_gfx_pixel_writer.sv - directed self-checking bench for gfx_pixel_writer
module tb_gfx_pixel_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  render_idx;
    logic [31:0] render_data;
    logic        render_start;
    logic        hflip;
    logic [2:0]  palette;
    logic [2:0]  zdepth;
    logic        zdepth_init;
    logic        last_pixel;
    logic        busy;
    logic [8:0]  wridx;
    logic [6:0]  wrdata;
    logic        wren;

    int checks = 0;
    int errors = 0;

    gfx_pixel_writer dut (
        .clk          (clk),
        .reset        (reset),
        .render_idx   (render_idx),
        .render_data  (render_data),
        .render_start (render_start),
        .hflip        (hflip),
        .palette      (palette),
        .zdepth       (zdepth),
        .zdepth_init  (zdepth_init),
        .last_pixel   (last_pixel),
        .busy         (busy),
        .wridx        (wridx),
        .wrdata       (wrdata),
        .wren         (wren)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [8:0] idx, input logic [31:0] data, input logic hf,
                         input logic [2:0] pal, input logic [2:0] z, input logic init);
        @(negedge clk);
        render_idx   = idx;
        render_data  = data;
        hflip        = hf;
        palette      = pal;
        zdepth       = z;
        zdepth_init  = init;
        render_start = 1'b1;
        @(negedge clk);
        render_start = 1'b0;
    endtask

    // Checks cycles T+1..T+10; mask bit i says pixel i must write, wd holds pixel 0 in its top byte.
    task automatic run_group(input string tag, input logic [8:0] idx, input logic [31:0] data,
                             input logic hf, input logic [2:0] pal, input logic [2:0] z,
                             input logic init, input logic [7:0] mask, input logic [63:0] wd);
        start(idx, data, hf, pal, z, init);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("%s busy k%0d", tag, k), 32'(busy), 32'(k <= 8));
            chk($sformatf("%s last k%0d", tag, k), 32'(last_pixel), 32'(k == 8));
            if (k >= 2 && k <= 9) begin
                chk($sformatf("%s wren p%0d", tag, k - 2), 32'(wren), 32'(mask[k-2]));
                if (mask[k-2]) begin
                    chk($sformatf("%s wridx p%0d", tag, k - 2), 32'(wridx), 32'(9'(idx + 9'(k - 2))));
                    chk($sformatf("%s wrdata p%0d", tag, k - 2), 32'(wrdata), 32'(wd[63 - 8*(k-2) -: 8]));
                end
            end else begin
                chk($sformatf("%s wren k%0d", tag, k), 32'(wren), 32'd0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset        = 1'b1;
        render_idx   = 9'd0;
        render_data  = 32'd0;
        render_start = 1'b0;
        hflip        = 1'b0;
        palette      = 3'd0;
        zdepth       = 3'd0;
        zdepth_init  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset last", 32'(last_pixel), 32'd0);
        chk("reset wren", 32'(wren), 32'd0);
        chk("reset wridx", 32'(wridx), 32'd0);
        chk("reset wrdata", 32'(wrdata), 32'd0);
        reset = 1'b0;

        run_group("basic", 9'd0, 32'h12345678, 1'b0, 3'd5, 3'd4, 1'b1, 8'hFF, 64'h5152535455565758);
        run_group("hflip", 9'd0, 32'h12345678, 1'b1, 3'd5, 3'd4, 1'b1, 8'hFF, 64'h5857565554535251);
        run_group("wrap", 9'd508, 32'h12345678, 1'b0, 3'd5, 3'd4, 1'b1, 8'hF0, 64'h5152535455565758);

        // Back-to-back groups, with a start in mid-group that must be ignored.
        start(9'd0, 32'h12345678, 1'b0, 3'd5, 3'd4, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("b2b busy k%0d", k), 32'(busy), 32'd1);
            chk($sformatf("b2b last k%0d", k), 32'(last_pixel), 32'd0);
            chk($sformatf("b2b wren k%0d", k), 32'(wren), 32'(k >= 2));
            if (k >= 2) chk($sformatf("b2b wridx k%0d", k), 32'(wridx), 32'(k - 2));
            render_start = (k == 4);
            render_idx   = (k == 4) ? 9'd200 : 9'd0;
            @(negedge clk);
        end
        chk("b2b last k8", 32'(last_pixel), 32'd1);
        chk("b2b wridx k8", 32'(wridx), 32'd6);
        render_idx   = 9'd8;
        render_start = 1'b1;
        @(negedge clk);
        render_start = 1'b0;
        for (int k = 9; k <= 19; k++) begin
            chk($sformatf("b2b busy k%0d", k), 32'(busy), 32'(k <= 16));
            chk($sformatf("b2b last k%0d", k), 32'(last_pixel), 32'(k == 16));
            chk($sformatf("b2b wren k%0d", k), 32'(wren), 32'(k <= 17));
            if (k <= 17) begin
                chk($sformatf("b2b wridx k%0d", k), 32'(wridx), 32'(k - 2));
                chk($sformatf("b2b wrdata k%0d", k), 32'(wrdata), 32'(8'h51 + 8'((k - 2) % 8)));
            end
            @(negedge clk);
        end

        run_group("z_init", 9'd100, 32'h12345678, 1'b0, 3'd5, 3'd4, 1'b1, 8'hFF, 64'h5152535455565758);
        run_group("z_low", 9'd100, 32'h11111111, 1'b0, 3'd1, 3'd2, 1'b0, 8'h00, 64'h0);
        run_group("z_high", 9'd100, 32'h03030303, 1'b0, 3'd2, 3'd6, 1'b0, 8'hAA, 64'h0023002300230023);
        run_group("z_mid", 9'd100, 32'h33333333, 1'b0, 3'd3, 3'd5, 1'b0, 8'h55, 64'h3300330033003300);

        // Reset asserted while pixel 3 is issued; start held with reset is ignored.
        start(9'd0, 32'h12345678, 1'b0, 3'd5, 3'd4, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst pre busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst wren", 32'(wren), 32'd0);
        chk("rst last", 32'(last_pixel), 32'd0);
        chk("rst wridx", 32'(wridx), 32'd0);
        chk("rst wrdata", 32'(wrdata), 32'd0);
        render_start = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        render_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst idle busy %0d", k), 32'(busy), 32'd0);
            chk($sformatf("rst idle wren %0d", k), 32'(wren), 32'd0);
            @(negedge clk);
        end
        run_group("post_rst", 9'd0, 32'h12345678, 1'b0, 3'd5, 3'd4, 1'b1, 8'hFF, 64'h5152535455565758);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
